spi_rom_loader: RTL and testbench

// - Consumes the received-byte stream of the SPI flash front end and writes it as a byte image into C64 memory.
// - Writes go through a ready/write handshake, starting at a programmable base address.
// - Sits between the SPI receive path (byte + strobe) and the RAM/ROM-shadow write port.
// - Buffers bytes in a small FIFO so that RAM stalls do not lose SPI data.

---
 rtl/spi_loader_pkg.sv | 21 ++
 rtl/spi_rom_loader_if.sv | 34 +++
 rtl/spi_byte_fifo.sv | 78 +++++++
 rtl/spi_rom_loader.sv | 169 ++++++++++++++++
 tb/tb_spi_rom_loader.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_loader_pkg.sv
// Shared types and defaults for the SPI ROM loader.
// The optional checksum is enabled with the CHECKSUM_EN macro; see spi_rom_loader.sv.
package spi_loader_pkg;

    localparam int ADDR_W_DEF     = 16;
    localparam int LEN_W_DEF      = 16;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } load_state_e;

    // Running mod-256 byte sum used by the checksum option.
    function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/spi_rom_loader_if.sv
// Byte stream from the SPI receive path plus the memory write port.
// master: the loader (consumes bytes, issues writes); slave: SPI/memory side.
interface spi_rom_loader_if
    import spi_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) ();

    logic [7:0]        byte_data;
    logic              byte_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic              mem_we;
    logic              mem_ready;

    modport master (
        input  byte_data,
        input  byte_valid,
        input  mem_ready,
        output mem_addr,
        output mem_data,
        output mem_we
    );

    modport slave (
        output byte_data,
        output byte_valid,
        output mem_ready,
        input  mem_addr,
        input  mem_data,
        input  mem_we
    );

endinterface

// File: rtl/spi_byte_fifo.sv
// Synchronous 8-bit FIFO. Full/empty are registered flags; the head byte is
// always visible on dout. A push while full is taken when a pop happens in
// the same cycle. DEPTH must be a power of two, >= 2.
module spi_byte_fifo
    import spi_loader_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [7:0]       mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nx_s;
    logic             full_r;
    logic             empty_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign dout  = mem_r[rd_ptr_r];
    assign full  = full_r;
    assign empty = empty_r;

    // Qualify push/pop against the flags and compute the next occupancy.
    always_comb begin
        do_pop_s  = pop && !empty_r;
        do_push_s = push && (!full_r || do_pop_s);
        cnt_nx_s  = cnt_r;
        if (do_push_s && !do_pop_s) begin
            cnt_nx_s = cnt_r + CNT_ONE;
        end else if (do_pop_s && !do_push_s) begin
            cnt_nx_s = cnt_r - CNT_ONE;
        end else begin
            cnt_nx_s = cnt_r;
        end
    end

    // Storage, pointers and registered full/empty flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            cnt_r   <= cnt_nx_s;
            full_r  <= (cnt_nx_s == CNT_FULL);
            empty_r <= (cnt_nx_s == {CNT_W{1'b0}});
        end
    end

endmodule

// File: rtl/spi_rom_loader.sv
// SPI ROM loader: writes a received SPI byte stream into memory starting at
// base_addr, buffering through a small FIFO so memory stalls lose no data.
// Optional feature macro CHECKSUM_EN adds an 8-bit sum of all written bytes.
module spi_rom_loader
    import spi_loader_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int LEN_W      = LEN_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [LEN_W-1:0]   length,
    spi_rom_loader_if.master   bus,
    output logic               busy,
    output logic               done,
`ifdef CHECKSUM_EN
    output logic [7:0]         checksum,
`endif
    output logic               overflow
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0]  LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    load_state_e       state_r;
    load_state_e       state_nx_s;
    logic [ADDR_W-1:0] addr_r;
    logic [LEN_W-1:0]  len_r;
    logic [LEN_W-1:0]  rx_cnt_r;
    logic              overflow_r;
    logic              busy_r;
    logic              done_r;
    logic              start_ok_s;
    logic              accept_s;
    logic              push_s;
    logic              drop_s;
    logic              pop_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [7:0]        fifo_dout_s;

    spi_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .din   (bus.byte_data),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // The FIFO head is the pending write; a non-empty FIFO means mem_we.
    assign bus.mem_we   = !fifo_empty_s;
    assign bus.mem_data = fifo_dout_s;
    assign bus.mem_addr = addr_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign overflow     = overflow_r;

    // Byte acceptance, FIFO push/drop decisions and write-port pop.
    always_comb begin
        pop_s    = !fifo_empty_s && bus.mem_ready;
        accept_s = (state_r == ST_LOAD) && bus.byte_valid && (rx_cnt_r < len_r);
        push_s   = accept_s && (!fifo_full_s || pop_s);
        drop_s   = accept_s && fifo_full_s && !pop_s;
    end

    // Next-state logic; start is honoured only in IDLE or DONE.
    always_comb begin
        state_nx_s = state_r;
        start_ok_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    start_ok_s = 1'b1;
                    if (length == {LEN_W{1'b0}}) begin
                        state_nx_s = ST_DONE;
                    end else begin
                        state_nx_s = ST_LOAD;
                    end
                end else begin
                    state_nx_s = state_r;
                end
            end
            ST_LOAD: begin
                if (rx_cnt_r == len_r) begin
                    state_nx_s = ST_DRAIN;
                end else begin
                    state_nx_s = ST_LOAD;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty_s) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_DRAIN;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State register with registered busy/done decodes of the next state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s == ST_LOAD) || (state_nx_s == ST_DRAIN);
            done_r  <= (state_nx_s == ST_DONE);
        end
    end

    // Load parameters, stream position, write address and sticky overflow.
    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_r     <= {ADDR_W{1'b0}};
            len_r      <= {LEN_W{1'b0}};
            rx_cnt_r   <= {LEN_W{1'b0}};
            overflow_r <= 1'b0;
        end else if (start_ok_s) begin
            addr_r     <= base_addr;
            len_r      <= length;
            rx_cnt_r   <= {LEN_W{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            // A dropped byte still advances rx_cnt so the stream stays aligned.
            if (accept_s) begin
                rx_cnt_r <= rx_cnt_r + LEN_ONE;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
            if (pop_s) begin
                addr_r <= addr_r + ADDR_ONE;
            end
        end
    end

`ifdef CHECKSUM_EN
    logic [7:0] checksum_r;

    assign checksum = checksum_r;

    // Sum of every byte accepted by the write port since the last start.
    always_ff @(posedge clk) begin
        if (!reset) begin
            checksum_r <= 8'h00;
        end else if (start_ok_s) begin
            checksum_r <= 8'h00;
        end else if (pop_s) begin
            checksum_r <= sum8(checksum_r, fifo_dout_s);
        end else begin
            checksum_r <= checksum_r;
        end
    end
`endif

endmodule

// File: tb/tb_spi_rom_loader.sv
// Self-checking bench for spi_rom_loader: expected writes are queued as bytes
// are driven and compared when the write port accepts them.
module tb_spi_rom_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] base_addr = 16'h0000;
    logic [15:0] length = 16'h0000;
    logic        busy;
    logic        done;
    logic        overflow;
`ifdef CHECKSUM_EN
    logic [7:0]  checksum;
`endif

    int checks_cnt = 0;
    int errors_cnt = 0;
    int wr_cnt = 0;
    int wr_before;

    logic [23:0] sb[$];
    logic [15:0] exp_addr = 16'h0000;

    logic        stall_r = 1'b0;
    logic [15:0] prev_addr;
    logic [7:0]  prev_data;

    spi_rom_loader_if #(.ADDR_W(16)) bus ();

    spi_rom_loader #(
        .ADDR_W     (16),
        .LEN_W      (16),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
`ifdef CHECKSUM_EN
        .checksum  (checksum),
`endif
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] b, input logic [15:0] l);
        base_addr = b;
        length    = l;
        start     = 1'b1;
        exp_addr  = b;
        cycles(1);
        start     = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input bit exp_wr);
        bus.byte_data  = d;
        bus.byte_valid = 1'b1;
        if (exp_wr) begin
            sb.push_back({exp_addr, d});
            exp_addr = exp_addr + 16'd1;
        end
        cycles(1);
        bus.byte_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 200) begin
            cycles(1);
            n++;
        end
        check("done", {31'd0, done}, 32'd1);
    endtask

    // Write-port monitor: scoreboard compare on acceptance, hold check on stall.
    always @(negedge clk) begin
        if (reset) begin
            if (stall_r) begin
                check("hold_we", {31'd0, bus.mem_we}, 32'd1);
                check("hold_addr", {16'd0, bus.mem_addr}, {16'd0, prev_addr});
                check("hold_data", {24'd0, bus.mem_data}, {24'd0, prev_data});
            end
            if (bus.mem_we && bus.mem_ready) begin
                wr_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_write", {16'd0, bus.mem_addr}, 32'hFFFF_FFFF);
                end else begin
                    logic [23:0] e;
                    e = sb.pop_front();
                    check("wr_addr", {16'd0, bus.mem_addr}, {16'd0, e[23:8]});
                    check("wr_data", {24'd0, bus.mem_data}, {24'd0, e[7:0]});
                end
            end
            stall_r   = bus.mem_we && !bus.mem_ready;
            prev_addr = bus.mem_addr;
            prev_data = bus.mem_data;
        end else begin
            stall_r = 1'b0;
        end
    end

    initial begin
        logic [7:0] basic_bytes [4];
        basic_bytes[0] = 8'h11;
        basic_bytes[1] = 8'h22;
        basic_bytes[2] = 8'h33;
        basic_bytes[3] = 8'h44;

        bus.byte_data  = 8'h00;
        bus.byte_valid = 1'b0;
        bus.mem_ready  = 1'b1;

        // Reset state
        cycles(3);
        check("rst_we", {31'd0, bus.mem_we}, 32'd0);
        check("rst_addr", {16'd0, bus.mem_addr}, 32'd0);
        check("rst_data", {24'd0, bus.mem_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        reset = 1'b1;
        cycles(2);

        // Basic load with latency-1 presentation of each byte
        do_start(16'hA000, 16'd4);
        check("basic_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            send_byte(basic_bytes[i], 1'b1);
            @(negedge clk);
            check("lat_we", {31'd0, bus.mem_we}, 32'd1);
            check("lat_data", {24'd0, bus.mem_data}, {24'd0, basic_bytes[i]});
            cycles(7);
        end
        wait_done();
        check("basic_ovf", {31'd0, overflow}, 32'd0);
        check("basic_busy_end", {31'd0, busy}, 32'd0);

        // Stall: three bytes held behind mem_ready=0, then back-to-back
        bus.mem_ready = 1'b0;
        do_start(16'h1000, 16'd3);
        send_byte(8'h5A, 1'b1);
        cycles(2);
        send_byte(8'h6B, 1'b1);
        cycles(2);
        send_byte(8'h7C, 1'b1);
        cycles(13);
        check("stall_addr", {16'd0, bus.mem_addr}, 32'h1000);
        check("stall_data", {24'd0, bus.mem_data}, 32'h5A);
        wr_before = wr_cnt;
        bus.mem_ready = 1'b1;
        cycles(3);
        check("stall_b2b", wr_cnt - wr_before, 32'd3);
        wait_done();

        // Overflow: 6 bytes into a 4-entry FIFO with no writes accepted
        bus.mem_ready = 1'b0;
        do_start(16'h2000, 16'd6);
        for (int i = 0; i < 6; i++) begin
            send_byte(8'hC0 + 8'(i), i < 4);
        end
        check("ovf_set", {31'd0, overflow}, 32'd1);
        wr_before = wr_cnt;
        bus.mem_ready = 1'b1;
        wait_done();
        check("ovf_writes", wr_cnt - wr_before, 32'd4);
        check("ovf_sticky", {31'd0, overflow}, 32'd1);

        // Address wrap; start also clears overflow
        do_start(16'hFFFE, 16'd3);
        check("ovf_clear", {31'd0, overflow}, 32'd0);
        send_byte(8'hE1, 1'b1);
        send_byte(8'hE2, 1'b1);
        send_byte(8'hE3, 1'b1);
        wait_done();

        // Extras: bytes while DONE, start while busy, bytes past length
        wr_before = wr_cnt;
        send_byte(8'h99, 1'b0);
        send_byte(8'h98, 1'b0);
        do_start(16'h5000, 16'd2);
        send_byte(8'hAA, 1'b1);
        base_addr = 16'h6000;
        length    = 16'd9;
        start     = 1'b1;
        cycles(1);
        start     = 1'b0;
        check("start_ignored_busy", {31'd0, busy}, 32'd1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b0);
        wait_done();
        cycles(4);
        check("extra_writes", wr_cnt - wr_before, 32'd2);

        // Abort mid-load
        bus.mem_ready = 1'b0;
        do_start(16'h3000, 16'd4);
        send_byte(8'h31, 1'b1);
        send_byte(8'h32, 1'b1);
        cycles(2);
        check("abort_pre_we", {31'd0, bus.mem_we}, 32'd1);
        reset = 1'b0;
        cycles(1);
        sb.delete();
        check("abort_we", {31'd0, bus.mem_we}, 32'd0);
        check("abort_addr", {16'd0, bus.mem_addr}, 32'd0);
        check("abort_data", {24'd0, bus.mem_data}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_ovf", {31'd0, overflow}, 32'd0);
        cycles(1);
        reset = 1'b1;
        bus.mem_ready = 1'b1;
        wr_before = wr_cnt;
        send_byte(8'h77, 1'b0);
        cycles(8);
        check("abort_no_wr", wr_cnt - wr_before, 32'd0);

        // Length zero from IDLE: done the cycle after start, no writes
        check("len0_pre_done", {31'd0, done}, 32'd0);
        do_start(16'h4000, 16'd0);
        check("len0_done", {31'd0, done}, 32'd1);
        check("len0_busy", {31'd0, busy}, 32'd0);
        cycles(5);
        check("len0_no_wr", wr_cnt - wr_before, 32'd0);

`ifdef CHECKSUM_EN
        // Checksum wraps mod 256
        do_start(16'h7000, 16'd2);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h02, 1'b1);
        wait_done();
        check("checksum", {24'd0, checksum}, 32'h01);
`endif

        cycles(2);
        check("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
